// File: rtl/omsp_dbg_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : omsp_dbg_uart_rx
// Purpose  : Debug-UART serial receive front-end. Synchronises the raw rxd
//            pin, optionally measures the baud rate from a 0x80 sync
//            character, then deserialises 8N1 bytes for the protocol FSM.
// Ports    : dbg_clk       - debug clock, all state on rising edge
//            dbg_rst_n     - asynchronous reset, active low
//            dbg_uart_rxd  - raw serial input, idle high, asynchronous
//            rx_sync_req   - level, request for baud re-measurement
//            rx_data       - last correctly received byte
//            rx_valid      - 1-cycle pulse, rx_data updated this cycle
//            rx_frame_err  - 1-cycle pulse, stop bit sampled low
//            baud_div      - current clocks-per-bit value
//            synced        - baud_div valid, byte reception enabled
// Config   : DBG_UART_AUTO_SYNC_EN - when defined, baud rate is measured
//            from the sync character; otherwise FIXED_BAUD_DIV is used and
//            synced is tied high.
// Revision : 1.0 - initial release
// ============================================================================
module omsp_dbg_uart_rx #(
    parameter int               DIV_W          = 16,
    parameter logic [DIV_W-1:0] FIXED_BAUD_DIV = 16'd86,
    parameter int               SYNC_STAGES    = 2
) (
    input  logic             dbg_clk,
    input  logic             dbg_rst_n,
    input  logic             dbg_uart_rxd,
    input  logic             rx_sync_req,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_frame_err,
    output logic [DIV_W-1:0] baud_div,
    output logic             synced
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_START   = 3'd1;
    localparam logic [2:0] c_ST_DATA    = 3'd2;
    localparam logic [2:0] c_ST_STOP    = 3'd3;
    localparam logic [2:0] c_ST_WAIT_HI = 3'd4;
    localparam logic [2:0] c_ST_SYNC    = 3'd5;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_prev;
    logic [2:0]             r_state;
    logic [DIV_W-1:0]       r_cnt;
    logic [2:0]             r_bit;
    logic [7:0]             r_shift;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_frame_err;

    logic                   w_rxd_s;
    logic                   w_fall;
    logic [DIV_W-1:0]       w_baud;
    logic                   w_go_sync;
    logic [DIV_W-1:0]       w_half_m1;
    logic [DIV_W-1:0]       w_full_m1;

    // Synchroniser shifts toward the MSB; the MSB is the clean rxd.
    always_ff @(posedge dbg_clk or negedge dbg_rst_n) begin
        if (!dbg_rst_n) begin
            r_sync     <= '1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], dbg_uart_rxd};
            r_rxd_prev <= w_rxd_s;
        end
    end

    assign w_rxd_s = r_sync[SYNC_STAGES-1];
    assign w_fall  = r_rxd_prev & ~w_rxd_s;

`ifdef DBG_UART_AUTO_SYNC_EN
    logic [DIV_W-1:0] r_baud_div;
    logic             r_synced;

    assign w_baud    = r_baud_div;
    // A sync request in the same cycle as an edge wins: the edge is
    // treated as the start of a new sync character.
    assign w_go_sync = ~r_synced | rx_sync_req;
    assign synced    = r_synced;
`else
    logic w_unused;

    assign w_baud    = FIXED_BAUD_DIV;
    assign w_go_sync = 1'b0;
    assign synced    = 1'b1;
    assign w_unused  = rx_sync_req;
`endif

    assign w_half_m1 = (w_baud >> 1) - DIV_W'(1);
    assign w_full_m1 = w_baud - DIV_W'(1);

    always_ff @(posedge dbg_clk or negedge dbg_rst_n) begin
        if (!dbg_rst_n) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_bit          <= '0;
            r_shift        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;
`ifdef DBG_UART_AUTO_SYNC_EN
            r_baud_div     <= '0;
            r_synced       <= 1'b0;
`endif
        end else begin
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
`ifdef DBG_UART_AUTO_SYNC_EN
                    if (rx_sync_req) begin
                        r_synced <= 1'b0;
                    end
`endif
                    if (w_fall) begin
                        r_bit <= '0;
                        if (w_go_sync) begin
                            // The edge cycle is already one low cycle, so
                            // the measurement starts at 1 to give L exactly.
                            r_state <= c_ST_SYNC;
                            r_cnt   <= DIV_W'(1);
                        end else begin
                            r_state <= c_ST_START;
                            r_cnt   <= '0;
                        end
                    end
                end
`ifdef DBG_UART_AUTO_SYNC_EN
                c_ST_SYNC: begin
                    if (!w_rxd_s) begin
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + DIV_W'(1);
                        end
                    end else if ((r_cnt != '1) &&
                                 (r_cnt[DIV_W-1:3] >= (DIV_W-3)'(4))) begin
                        // 0x80 holds the line low for 8 bit times.
                        r_baud_div <= r_cnt >> 3;
                        r_synced   <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_state <= c_ST_WAIT_HI;
                    end
                end
`endif
                c_ST_START: begin
                    if (r_cnt == w_half_m1) begin
                        r_cnt   <= '0;
                        r_state <= w_rxd_s ? c_ST_IDLE : c_ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                c_ST_DATA: begin
                    if (r_cnt == w_full_m1) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxd_s, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= c_ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                c_ST_STOP: begin
                    if (r_cnt == w_full_m1) begin
                        r_cnt <= '0;
                        if (w_rxd_s) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_rx_frame_err <= 1'b1;
                            r_state        <= c_ST_WAIT_HI;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                c_ST_WAIT_HI: begin
                    if (w_rxd_s) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_frame_err;
    assign baud_div     = w_baud;

endmodule
`default_nettype wire
